// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-bit and status signals of the pattern detector.
interface seq_detect_ctrl_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_max;
  logic             start;
  logic             stop;
  logic             bit_valid;
  logic             bit_in;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_max,
    output start, stop, bit_valid, bit_in,
    input  cfg_ready, match, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_max,
    input  start, stop, bit_valid, bit_in,
    output cfg_ready, match, match_count, busy, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: latches a pattern/length/overlap/limit
// config, then scans a qualified bit stream, pulsing match and counting hits.
module seq_detect_ctrl #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] max_q;
  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic             match_q;
  logic [CNT_W-1:0] count_q;

  logic [LEN_W-1:0] cfg_len_eff;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] len_mask;
  logic             hit;
  logic [CNT_W-1:0] count_inc;
  logic             limit_hit;

  // Next-history, fill, hit detection and saturating count for the current bit.
  always_comb begin
    cfg_len_eff = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      cfg_len_eff = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(PAT_W)) begin
      cfg_len_eff = LEN_W'(PAT_W);
    end
    hist_next = {hist_q[PAT_W-2:0], bus.bit_in};
    fill_next = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    // Only the low len bits of history and pattern take part in the compare.
    len_mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit       = (fill_next == len_q) && ((hist_next & len_mask) == (pat_q & len_mask));
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    limit_hit = (max_q != '0) && (count_inc == max_q);
  end

  // Control FSM with config registers, scan state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b0;
      max_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      match_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          // A config request wins over a simultaneous start.
          if (bus.cfg_valid) begin
            pat_q <= bus.cfg_pattern;
            len_q <= cfg_len_eff;
            ovl_q <= bus.cfg_overlap;
            max_q <= bus.cfg_max;
          end else if (bus.start) begin
            state_q <= StArmed;
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
          end
        end
        StArmed: begin
          // Stop discards any bit presented in the same cycle.
          if (bus.stop) begin
            state_q <= StIdle;
          end else if (bus.bit_valid) begin
            hist_q <= hist_next;
            if (hit) begin
              match_q <= 1'b1;
              count_q <= count_inc;
              fill_q  <= ovl_q ? fill_next : '0;
              if (limit_hit) begin
                state_q <= StDone;
              end
            end else begin
              fill_q <= fill_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cfg_ready   = (state_q != StArmed);
  assign bus.busy        = (state_q == StArmed);
  assign bus.done        = (state_q == StDone);
  assign bus.match       = match_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a bit-queue model checked every cycle plus
// literal expectations for each directed scenario.
module tb_seq_detect_ctrl;
  localparam int unsigned PAT_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: mode 0 idle / 1 armed / 2 done; window holds bits received since
  // arming or since the last non-overlapping hit, oldest first.
  int         m_mode;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_max;
  bit         m_win[$];
  int         m_count;
  bit         m_match;

  task automatic model_reset();
    m_mode = 0; m_pat = '0; m_len = 1; m_ovl = 0; m_max = 0;
    m_win.delete(); m_count = 0; m_match = 0;
  endtask

  task automatic model_step();
    bit hit;
    m_match = 0;
    if (m_mode != 1) begin
      if (bus.cfg_valid) begin
        m_pat = bus.cfg_pattern;
        m_len = (bus.cfg_len == 0) ? 1 : ((int'(bus.cfg_len) > PAT_W) ? PAT_W : int'(bus.cfg_len));
        m_ovl = bus.cfg_overlap;
        m_max = int'(bus.cfg_max);
      end else if (bus.start) begin
        m_mode = 1; m_win.delete(); m_count = 0;
      end
    end else if (bus.stop) begin
      m_mode = 0;
    end else if (bus.bit_valid) begin
      m_win.push_back(bus.bit_in);
      if (m_win.size() > m_len) void'(m_win.pop_front());
      hit = (m_win.size() == m_len);
      for (int k = 0; k < m_len; k++) begin
        if (m_win[k] != m_pat[m_len - 1 - k]) hit = 0;
      end
      if (hit) begin
        m_match = 1;
        if (m_count < CNT_MAX) m_count++;
        if (!m_ovl) m_win.delete();
        if (m_max != 0 && m_count == m_max) m_mode = 2;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cmp_match", 32'(bus.match), 32'(m_match));
    check("cmp_count", 32'(bus.match_count), 32'(m_count));
    check("cmp_busy", 32'(bus.busy), 32'(m_mode == 1));
    check("cmp_done", 32'(bus.done), 32'(m_mode == 2));
    check("cmp_cfg_ready", 32'(bus.cfg_ready), 32'(m_mode != 1));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [7:0] mx);
    bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_overlap = ovl; bus.cfg_max = mx;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  // seq[i] is the i-th bit sent; pulses[i] is match seen right after it.
  task automatic send(input logic [63:0] seq, input int n, input int gap_at,
                      output logic [63:0] pulses);
    pulses = '0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) tick();
      bus.bit_valid = 1'b1;
      bus.bit_in    = seq[i];
      tick();
      pulses[i]     = bus.match;
      bus.bit_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] p;
    model_reset();
    bus.cfg_valid = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
    bus.cfg_max = 0; bus.start = 0; bus.stop = 0; bus.bit_valid = 0; bus.bit_in = 0;
    #12;
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_count", 32'(bus.match_count), 32'd0);
    check("rst_match", 32'(bus.match), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 8 x 1 pattern, overlapping, ten ones
    do_cfg(8'hFF, 4'd8, 1'b1, 8'd0);
    go();
    send(64'h3FF, 10, -1, p);
    check("t1_pulses", p[31:0], 32'h380);
    check("t1_count", 32'(bus.match_count), 32'd3);
    check("t1_busy", 32'(bus.busy), 32'd1);
    halt();

    // 2: same, non-overlapping, sixteen ones
    do_cfg(8'hFF, 4'd8, 1'b0, 8'd0);
    go();
    send(64'hFFFF, 16, -1, p);
    check("t2_pulses", p[31:0], 32'h8080);
    check("t2_count", 32'(bus.match_count), 32'd2);
    halt();

    // 3: 1101 overlapping, without and with a gap
    do_cfg(8'h0D, 4'd4, 1'b1, 8'd0);
    go();
    send(64'h5B, 7, -1, p);
    check("t3_pulses", p[31:0], 32'h48);
    check("t3_count", 32'(bus.match_count), 32'd2);
    halt();
    go();
    send(64'h5B, 7, 5, p);
    check("t3_gap_pulses", p[31:0], 32'h48);
    check("t3_gap_count", 32'(bus.match_count), 32'd2);
    halt();

    // 4: limit of 2 reaches DONE, then reconfigure and re-arm
    do_cfg(8'h03, 4'd2, 1'b1, 8'd2);
    go();
    send(64'h1F, 5, -1, p);
    check("t4_pulses", p[31:0], 32'h6);
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("t4_count", 32'(bus.match_count), 32'd2);
    do_cfg(8'h03, 4'd2, 1'b1, 8'd0);
    check("t4_done_after_cfg", 32'(bus.done), 32'd1);
    go();
    check("t4_rearm_count", 32'(bus.match_count), 32'd0);
    check("t4_rearm_busy", 32'(bus.busy), 32'd1);
    halt();

    // 5a: stop together with the completing bit
    go();
    send(64'h1, 1, -1, p);
    bus.stop = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    tick();
    bus.stop = 1'b0; bus.bit_valid = 1'b0;
    check("t5_stop_match", 32'(bus.match), 32'd0);
    check("t5_stop_busy", 32'(bus.busy), 32'd0);
    check("t5_stop_count", 32'(bus.match_count), 32'd0);

    // 5b: cfg together with start (len=0 stored as 1)
    bus.cfg_pattern = 8'h01; bus.cfg_len = 4'd0; bus.cfg_overlap = 1'b0; bus.cfg_max = 8'd0;
    bus.cfg_valid = 1'b1; bus.start = 1'b1;
    tick();
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    check("t5_cfgstart_busy", 32'(bus.busy), 32'd0);
    go();
    send(64'h5, 3, -1, p);
    check("t5_len0_pulses", p[31:0], 32'h5);
    check("t5_len0_count", 32'(bus.match_count), 32'd2);

    // 5c: counter saturation
    for (int b = 0; b < 5; b++) send(64'hFFF_FFFF_FFFF_FFFF, 60, -1, p);
    check("t5_saturate", 32'(bus.match_count), 32'd255);
    halt();

    // 6: asynchronous reset mid-scan, right after a match pulse
    do_cfg(8'hFF, 4'd8, 1'b1, 8'd0);
    go();
    send(64'h3FF, 10, -1, p);
    check("t6_pre_count", 32'(bus.match_count), 32'd3);
    check("t6_pre_match", 32'(bus.match), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_match", 32'(bus.match), 32'd0);
    check("t6_rst_count", 32'(bus.match_count), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    go();
    send(64'h2, 3, -1, p);
    check("t6_default_pulses", p[31:0], 32'h5);
    check("t6_default_count", 32'(bus.match_count), 32'd2);
    halt();

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
